sdram_clk_ctrl: RTL

- Parametrised DCM supervisor for the SDRAM clock domain.
- Sequences the DCM reset and waits for lock with a timeout and bounded retries.
- Applies a programmable dynamic phase shift through the DCM PSEN/PSINCDEC/PSDONE handshake, then reports a qualified ready.
- Sits beside the DCM_SP/BUFG pair. The DCM's PSCLK is tied to clk, so every DCM-facing signal is on clk.

---
 rtl/sdram_clk_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/sdram_clk_ctrl.sv
// DCM supervisor for the SDRAM clock domain: sequences DCM reset, waits for a
// settled lock with timeout and bounded retries, then walks the DCM fine phase
// shift to a programmable target before reporting ready.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_RESET_DCM  | dcm_rst held high for RST_PULSE cycles, applied phase is 0
// S_WAIT_LOCK  | waiting up to LOCK_TIMEOUT cycles for dcm_locked
// S_SETTLE     | requiring SETTLE consecutive locked cycles
// S_SHIFT      | single-cycle PSEN with PSINCDEC toward the target
// S_SHIFT_WAIT | waiting up to LOCK_TIMEOUT cycles for PSDONE
// S_RUN        | locked, settled, at target phase; ready asserted
// S_FAULT      | retries exhausted; DCM held in reset until rst
module sdram_clk_ctrl #(
    parameter int RST_PULSE    = 3,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int SETTLE       = 16,
    parameter int MAX_RETRY    = 4,
    parameter int PHASE_W      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [PHASE_W-1:0] phase_target,
    input  logic                      phase_load,
    output logic                      dcm_rst,
    input  logic                      dcm_locked,
    output logic                      dcm_psen,
    output logic                      dcm_psincdec,
    input  logic                      dcm_psdone,
    output logic signed [PHASE_W-1:0] phase_current,
    output logic [2:0]                retry_count,
    output logic                      ready,
    output logic                      fault
);

    localparam int T_MAX0 = (LOCK_TIMEOUT > SETTLE) ? LOCK_TIMEOUT : SETTLE;
    localparam int T_MAX  = (T_MAX0 > RST_PULSE) ? T_MAX0 : RST_PULSE;
    localparam int TMR_W  = $clog2(T_MAX + 1);

    // Timers are down-counters loaded with (length - 1); terminal count is 0.
    localparam logic [TMR_W-1:0] T_RST    = TMR_W'(RST_PULSE - 1);
    localparam logic [TMR_W-1:0] T_LOCK   = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] T_SETTLE = TMR_W'(SETTLE - 1);
    localparam logic [2:0]       RETRY_LIM = 3'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RESET_DCM,
        S_WAIT_LOCK,
        S_SETTLE,
        S_SHIFT,
        S_SHIFT_WAIT,
        S_RUN,
        S_FAULT
    } state_t;

    state_t                      state_q, state_nxt;
    logic [TMR_W-1:0]            timer_q, timer_nxt;
    logic signed [PHASE_W-1:0]   target_q, target_nxt;
    logic signed [PHASE_W-1:0]   phase_nxt;
    logic signed [PHASE_W-1:0]   ph_step;
    logic signed [PHASE_W-1:0]   tgt_eff;
    logic [2:0]                  retry_nxt, retry_inc;
    logic                        dcm_rst_nxt, psen_nxt, incdec_nxt, ready_nxt, fault_nxt;
    logic                        fail, go_reset, go_fault, go_shift, go_run;

    // Next-state and next-output decode; all outputs are registered from here.
    always_comb begin
        state_nxt   = state_q;
        timer_nxt   = timer_q;
        phase_nxt   = phase_current;
        retry_nxt   = retry_count;
        dcm_rst_nxt = dcm_rst;
        psen_nxt    = 1'b0;
        incdec_nxt  = dcm_psincdec;
        ready_nxt   = ready;
        fault_nxt   = fault;
        fail        = 1'b0;
        go_reset    = 1'b0;
        go_fault    = 1'b0;
        go_shift    = 1'b0;
        go_run      = 1'b0;

        // A load in this cycle is already the target for any decision made now.
        tgt_eff    = phase_load ? phase_target : target_q;
        target_nxt = tgt_eff;
        ph_step    = dcm_psincdec ? (phase_current + PHASE_W'(1))
                                  : (phase_current - PHASE_W'(1));
        retry_inc  = (retry_count == 3'd7) ? retry_count : (retry_count + 3'd1);

        case (state_q)
            S_RESET_DCM: begin
                phase_nxt   = '0;
                dcm_rst_nxt = 1'b1;
                if (timer_q == '0) begin
                    state_nxt   = S_WAIT_LOCK;
                    dcm_rst_nxt = 1'b0;
                    timer_nxt   = T_LOCK;
                end else begin
                    timer_nxt = timer_q - TMR_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (dcm_locked) begin
                    state_nxt = S_SETTLE;
                    timer_nxt = T_SETTLE;
                end else if (timer_q == '0) begin
                    fail = 1'b1;
                end else begin
                    timer_nxt = timer_q - TMR_W'(1);
                end
            end
            S_SETTLE: begin
                if (!dcm_locked) begin
                    fail = 1'b1;
                end else if (timer_q == '0) begin
                    if (tgt_eff != phase_current) go_shift = 1'b1;
                    else                          go_run   = 1'b1;
                end else begin
                    timer_nxt = timer_q - TMR_W'(1);
                end
            end
            S_SHIFT: begin
                state_nxt = S_SHIFT_WAIT;
                timer_nxt = T_LOCK;
            end
            S_SHIFT_WAIT: begin
                if (!dcm_locked) begin
                    fail = 1'b1;
                end else if (dcm_psdone) begin
                    phase_nxt = ph_step;
                    if (ph_step == tgt_eff) go_run   = 1'b1;
                    else                    go_shift = 1'b1;
                end else if (timer_q == '0) begin
                    fail = 1'b1;
                end else begin
                    timer_nxt = timer_q - TMR_W'(1);
                end
            end
            S_RUN: begin
                retry_nxt = '0;
                // Losing lock while running is a recovery, not a failed attempt.
                if (!dcm_locked) begin
                    go_reset = 1'b1;
                end else if (phase_load && (phase_target != phase_current)) begin
                    go_shift = 1'b1;
                end
            end
            S_FAULT: begin
                dcm_rst_nxt = 1'b1;
                fault_nxt   = 1'b1;
                ready_nxt   = 1'b0;
            end
            default: go_reset = 1'b1;
        endcase

        if (fail) begin
            retry_nxt = retry_inc;
            if (retry_inc == RETRY_LIM) go_fault = 1'b1;
            else                        go_reset = 1'b1;
        end

        if (go_reset) begin
            state_nxt   = S_RESET_DCM;
            timer_nxt   = T_RST;
            dcm_rst_nxt = 1'b1;
            phase_nxt   = '0;
            ready_nxt   = 1'b0;
        end
        if (go_fault) begin
            state_nxt   = S_FAULT;
            dcm_rst_nxt = 1'b1;
            fault_nxt   = 1'b1;
            ready_nxt   = 1'b0;
        end
        if (go_shift) begin
            state_nxt  = S_SHIFT;
            psen_nxt   = 1'b1;
            incdec_nxt = (tgt_eff > phase_nxt);
            ready_nxt  = 1'b0;
        end
        if (go_run) begin
            state_nxt = S_RUN;
            ready_nxt = 1'b1;
            retry_nxt = '0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_RESET_DCM;
            timer_q       <= T_RST;
            target_q      <= '0;
            phase_current <= '0;
            retry_count   <= '0;
            dcm_rst       <= 1'b1;
            dcm_psen      <= 1'b0;
            dcm_psincdec  <= 1'b0;
            ready         <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            timer_q       <= timer_nxt;
            target_q      <= target_nxt;
            phase_current <= phase_nxt;
            retry_count   <= retry_nxt;
            dcm_rst       <= dcm_rst_nxt;
            dcm_psen      <= psen_nxt;
            dcm_psincdec  <= incdec_nxt;
            ready         <= ready_nxt;
            fault         <= fault_nxt;
        end
    end

endmodule
